traffic_lamp_guard: RTL and testbench

//  Output stage directly downstream of the Moore traffic-light FSM. Registers the FSM's r/y/g

---
 rtl/traffic_lamp_guard.sv | 127 ++++++++++++
 tb/tb_traffic_lamp_guard.sv | 121 ++++++++++++
 2 files changed

// File: rtl/traffic_lamp_guard.sv
// Registered lamp-drive stage behind the traffic-light FSM. It watches for multi-lamp
// and all-dark requests and falls back to latched flashing amber until the operator clears it.
module traffic_lamp_guard #(
  parameter int CONFLICT_CYCLES = 2,
  parameter int DARK_MAX        = 3,
  parameter int FLASH_HALF      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       r_in,
  input  logic       y_in,
  input  logic       g_in,
  input  logic       fault_clr,
  output logic       lamp_r,
  output logic       lamp_y,
  output logic       lamp_g,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int CW = $clog2(CONFLICT_CYCLES + 1);
  localparam int DW = $clog2(DARK_MAX + 1);
  localparam int FW = $clog2(FLASH_HALF + 1);

  localparam logic [CW-1:0] CONF_LAST  = CW'(CONFLICT_CYCLES - 1);
  localparam logic [DW-1:0] DARK_LAST  = DW'(DARK_MAX - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);
  localparam logic [CW-1:0] CONF_SAT   = CW'(CONFLICT_CYCLES);
  localparam logic [DW-1:0] DARK_SAT   = DW'(DARK_MAX);

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_MULTI = 2'b01;
  localparam logic [1:0] CODE_DARK  = 2'b10;

  typedef enum logic {PASS, FLASH} state_t;

  state_t        state_q;
  logic [CW-1:0] conf_cnt_q;
  logic [DW-1:0] dark_cnt_q;
  logic [FW-1:0] flash_cnt_q;

  logic [1:0] n_high;
  logic       is_legal;
  logic       is_multi;
  logic       is_dark;

  always_comb begin
    n_high   = {1'b0, r_in} + {1'b0, y_in} + {1'b0, g_in};
    is_legal = (n_high == 2'd1);
    is_multi = (n_high >= 2'd2);
    is_dark  = (n_high == 2'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= PASS;
      lamp_r      <= 1'b1;
      lamp_y      <= 1'b0;
      lamp_g      <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= CODE_NONE;
      conf_cnt_q  <= '0;
      dark_cnt_q  <= '0;
      flash_cnt_q <= '0;
    end else begin
      case (state_q)
        PASS: begin
          if (is_legal) begin
            {lamp_r, lamp_y, lamp_g} <= {r_in, y_in, g_in};
            conf_cnt_q <= '0;
            dark_cnt_q <= '0;
          end else if (is_dark) begin
            conf_cnt_q <= '0;
            if (dark_cnt_q >= DARK_LAST) begin
              state_q     <= FLASH;
              fault       <= 1'b1;
              fault_code  <= CODE_DARK;
              {lamp_r, lamp_y, lamp_g} <= 3'b010;
              flash_cnt_q <= '0;
              dark_cnt_q  <= '0;
            end else begin
              {lamp_r, lamp_y, lamp_g} <= 3'b000;
              if (dark_cnt_q != DARK_SAT) dark_cnt_q <= dark_cnt_q + DW'(1);
            end
          end else if (is_multi) begin
            dark_cnt_q <= '0;
            // Conflicting requests are blanked to red on the very first sample.
            if (conf_cnt_q >= CONF_LAST) begin
              state_q     <= FLASH;
              fault       <= 1'b1;
              fault_code  <= CODE_MULTI;
              {lamp_r, lamp_y, lamp_g} <= 3'b010;
              flash_cnt_q <= '0;
              conf_cnt_q  <= '0;
            end else begin
              {lamp_r, lamp_y, lamp_g} <= 3'b100;
              if (conf_cnt_q != CONF_SAT) conf_cnt_q <= conf_cnt_q + CW'(1);
            end
          end
        end
        FLASH: begin
          if (fault_clr && is_legal) begin
            state_q     <= PASS;
            fault       <= 1'b0;
            fault_code  <= CODE_NONE;
            {lamp_r, lamp_y, lamp_g} <= {r_in, y_in, g_in};
            conf_cnt_q  <= '0;
            dark_cnt_q  <= '0;
            flash_cnt_q <= '0;
          end else begin
            lamp_r <= 1'b0;
            lamp_g <= 1'b0;
            // Half-period counter; amber toggles as it wraps.
            if (flash_cnt_q >= FLASH_LAST) begin
              flash_cnt_q <= '0;
              lamp_y      <= ~lamp_y;
            end else begin
              flash_cnt_q <= flash_cnt_q + FW'(1);
            end
          end
        end
        default: state_q <= PASS;
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_lamp_guard.sv
// Directed bench for traffic_lamp_guard with default parameters (2/3/4).
// Expected outputs are packed as {lamp_r, lamp_y, lamp_g, fault, fault_code[1:0]}.
module tb_traffic_lamp_guard;

  logic       clk = 1'b0;
  logic       reset;
  logic       r_in, y_in, g_in, fault_clr;
  logic       lamp_r, lamp_y, lamp_g, fault;
  logic [1:0] fault_code;

  int checks   = 0;
  int failures = 0;

  traffic_lamp_guard #(.CONFLICT_CYCLES(2), .DARK_MAX(3), .FLASH_HALF(4)) dut (
    .clk(clk), .reset(reset), .r_in(r_in), .y_in(y_in), .g_in(g_in),
    .fault_clr(fault_clr), .lamp_r(lamp_r), .lamp_y(lamp_y), .lamp_g(lamp_g),
    .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  task automatic check_out(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got rygf_c=%b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {lamp_r, lamp_y, lamp_g, fault, fault_code};
  endfunction

  // Apply inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic [2:0] ryg, input logic clr, input string tag,
                      input logic [5:0] exp);
    {r_in, y_in, g_in} = ryg;
    fault_clr = clr;
    @(posedge clk);
    #1;
    check_out(tag, outs(), exp);
  endtask

  logic [2:0] cyc [4];

  initial begin
    cyc[0] = 3'b000; cyc[1] = 3'b100; cyc[2] = 3'b010; cyc[3] = 3'b001;
    reset = 1'b1;
    {r_in, y_in, g_in} = 3'b000;
    fault_clr = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_out("reset_state", outs(), 6'b100_0_00);
    reset = 1'b0;

    // Normal FSM cycle: lamps follow one cycle later, no fault.
    for (int k = 0; k < 8; k++)
      step(cyc[k % 4], 1'b0, "fsm_cycle", {cyc[k % 4], 3'b0_00});

    // Single multi-lamp sample is blanked to red but does not fault.
    step(3'b101, 1'b0, "multi_once",     6'b100_0_00);
    step(3'b100, 1'b0, "multi_recover",  6'b100_0_00);
    step(3'b110, 1'b1, "multi_once_clr", 6'b100_0_00);
    step(3'b010, 1'b0, "legal_after",    6'b010_0_00);

    // Two consecutive conflicts -> flashing amber, code 01.
    step(3'b110, 1'b0, "conf_1",     6'b100_0_00);
    step(3'b110, 1'b0, "conf_fault", 6'b010_1_01);
    step(3'b000, 1'b0, "flash_h1",   6'b010_1_01);
    step(3'b000, 1'b0, "flash_h2",   6'b010_1_01);
    step(3'b110, 1'b0, "flash_h3",   6'b010_1_01);
    step(3'b000, 1'b0, "flash_l0",   6'b000_1_01);
    step(3'b000, 1'b0, "flash_l1",   6'b000_1_01);
    step(3'b110, 1'b1, "clr_multi_ignored", 6'b000_1_01);
    step(3'b000, 1'b1, "clr_dark_ignored",  6'b000_1_01);
    step(3'b000, 1'b0, "flash_hi_again",    6'b010_1_01);
    step(3'b010, 1'b1, "clr_legal",  6'b010_0_00);
    step(3'b010, 1'b0, "after_clr",  6'b010_0_00);

    // Three dark samples -> fault code 10.
    step(3'b000, 1'b0, "dark_1",     6'b000_0_00);
    step(3'b000, 1'b0, "dark_2",     6'b000_0_00);
    step(3'b000, 1'b0, "dark_fault", 6'b010_1_10);
    step(3'b110, 1'b0, "dark_code_held", 6'b010_1_10);
    step(3'b100, 1'b1, "dark_clr",   6'b100_0_00);

    // Two dark samples then legal: no fault, counter restarts.
    step(3'b000, 1'b0, "dark2_a",    6'b000_0_00);
    step(3'b000, 1'b0, "dark2_b",    6'b000_0_00);
    step(3'b100, 1'b0, "dark2_legal",6'b100_0_00);
    step(3'b000, 1'b0, "dark2_c",    6'b000_0_00);
    step(3'b000, 1'b0, "dark2_d",    6'b000_0_00);
    step(3'b001, 1'b0, "dark2_g",    6'b001_0_00);

    // Class change resets the other counter.
    step(3'b000, 1'b0, "mix_dark",   6'b000_0_00);
    step(3'b011, 1'b0, "mix_multi",  6'b100_0_00);
    step(3'b000, 1'b0, "mix_dark2",  6'b000_0_00);
    step(3'b000, 1'b0, "mix_dark3",  6'b000_0_00);

    // Asynchronous reset mid-FLASH.
    step(3'b100, 1'b0, "pre_f6",     6'b100_0_00);
    step(3'b011, 1'b0, "f6_conf1",   6'b100_0_00);
    step(3'b011, 1'b0, "f6_fault",   6'b010_1_01);
    #3;
    reset = 1'b1;
    #1;
    check_out("async_reset", outs(), 6'b100_0_00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_out("reset_hold", outs(), 6'b100_0_00);
    step(3'b011, 1'b0, "post_reset_conf1", 6'b100_0_00);
    step(3'b001, 1'b0, "post_reset_legal", 6'b001_0_00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
